// File: rtl/inst_rom_loader_if.sv
// inst_rom_loader_if: byte-stream handshake plus instruction-memory write bus.
// The master modport drives the byte stream and observes the memory writes.
// The slave modport is the loader's side of the same signals.
interface inst_rom_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;

  modport master (
    output byte_i, byte_valid_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    input  byte_i, byte_valid_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot-time instruction memory writer.
// Consumes a byte stream: 4-byte little-endian word count N, then N
// little-endian 32-bit words, each written to the instruction memory
// through a single-cycle write strobe. The core is held in reset until the
// image is complete.
// Optional feature macro: LOADER_CKSUM_EN -- when defined, a trailing byte
// must equal the XOR of every accepted length/data byte, else the load fails.
// All outputs come straight from flops; no combinational path from the
// byte stream to any output.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  inst_rom_loader_if.slave      bus,
  input  logic                  start_i,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Largest legal word count: the whole memory.
  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // State entered once the last word is written (or N == 0).
`ifdef LOADER_CKSUM_EN
  localparam state_t S_TAIL = S_CKSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  // Control state
  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
`ifdef LOADER_CKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  // Data shift registers
  logic [31:0]       len_q, word_q;
  logic [31:0]       len_sh, word_sh;

  // Registered outputs
  logic              byte_ready_q;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q;
  logic              done_q;
  logic              err_q;

  logic              take;
  logic              rearm;

  // States in which the loader consumes stream bytes.
  function automatic logic rx_state(input state_t s);
    logic r;
    r = 1'b0;
    case (s)
      S_LEN, S_DATA: r = 1'b1;
`ifdef LOADER_CKSUM_EN
      S_CKSUM:       r = 1'b1;
`endif
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

  assign take    = bus.byte_valid_i & byte_ready_q;
  assign rearm   = start_i & ((state_q == S_DONE) | (state_q == S_ERR));
  assign len_sh  = {bus.byte_i, len_q[31:8]};
  assign word_sh = {bus.byte_i, word_q[31:8]};

  // Next-state and next-output decode for the load sequence
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
`ifdef LOADER_CKSUM_EN
    xor_d       = xor_q;
`endif
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_LEN: begin
        if (take) begin
          cnt_d = cnt_q + 2'd1;
`ifdef LOADER_CKSUM_EN
          xor_d = xor_q ^ bus.byte_i;
`endif
          if (cnt_q == 2'd3) begin
            if ({1'b0, len_sh} > CAP) begin
              state_d = S_ERR;
            end else if (len_sh == 32'd0) begin
              state_d = S_TAIL;
            end else begin
              state_d = S_DATA;
              idx_d   = '0;
            end
          end
        end
      end
      S_DATA: begin
        if (take) begin
          cnt_d = cnt_q + 2'd1;
`ifdef LOADER_CKSUM_EN
          xor_d = xor_q ^ bus.byte_i;
`endif
          if (cnt_q == 2'd3) begin
            state_d     = S_WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q[ADDR_W-1:0];
            mem_wdata_d = word_sh;
          end
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 1'b1;
        if (32'(idx_d) == len_q) state_d = S_TAIL;
        else                     state_d = S_DATA;
      end
`ifdef LOADER_CKSUM_EN
      S_CKSUM: begin
        if (take) state_d = (bus.byte_i == xor_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LEN;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef LOADER_CKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      default: state_d = S_LEN;
    endcase
  end

  // FSM state and registered outputs; outputs decode from the next state
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_LEN;
      cnt_q        <= '0;
      idx_q        <= '0;
`ifdef LOADER_CKSUM_EN
      xor_q        <= '0;
`endif
      byte_ready_q <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
`ifdef LOADER_CKSUM_EN
      xor_q        <= xor_d;
`endif
      byte_ready_q <= rx_state(state_d);
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= (state_d != S_DONE);
      done_q       <= (state_d == S_DONE);
      err_q        <= (state_d == S_ERR);
    end
  end

  // Length and word shift registers: bytes arrive LSB first; a full
  // 4-byte shift always overwrites stale contents, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (rearm) begin
      len_q  <= '0;
      word_q <= '0;
    end else begin
      if (take && (state_q == S_LEN))  len_q  <= len_sh;
      if (take && (state_q == S_DATA)) word_q <= word_sh;
    end
  end

  assign bus.byte_ready_o = byte_ready_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign cpu_hold_o       = cpu_hold_q;
  assign done_o           = done_q;
  assign err_o            = err_q;

endmodule
